// File: rtl/psimd_decode_stage.sv
`timescale 1ns/1ps
// psimd_decode_stage: registered decode of the PSIMD DLFloat opcodes with a RAW/WAW destination scoreboard.
// Define PSIMD_DEC_PERF_EN to build the saturating issue/stall performance counters.
module psimd_decode_stage #(
  parameter int NREGS         = 32,
  parameter int MAX_INFLIGHT  = 4,
  parameter int ILLEGAL_STALL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ena,
  output logic [2:0]  rm,
  output logic [1:0]  sel1,
  output logic [2:0]  sel2,
  output logic        op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  output logic [4:0]  rd,
  output logic        wr_enable,
  output logic        sp,
  output logic        logic_fti_ctrl,
  output logic        illegal,
  output logic [3:0]  inflight,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] OPC_FP  = 7'b1011011;
  localparam logic [6:0] OPC_FMA = 7'b0011011;
  localparam logic [6:0] OPC_FMS = 7'b0111011;
  localparam logic [6:0] OPC_ST  = 7'b0101011;

  typedef struct packed {
    logic [3:0] ena;
    logic [2:0] rm;
    logic [1:0] sel1;
    logic [2:0] sel2;
    logic       op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       wr_enable;
    logic       sp;
    logic       fti;
    logic       illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_IDLE = '{ena: 4'd0, rm: 3'd0, sel1: 2'd0, sel2: 3'd0, op: 1'b0,
                                      rs1: 5'd0, rs2: 5'd0, rs3: 5'd0, rd: 5'd0,
                                      wr_enable: 1'b0, sp: 1'b1, fti: 1'b1, illegal: 1'b0};

  bundle_t          bundle_p0, bundle_p1;
  logic             vld_p1;
  logic             use1_p0, use2_p0, use3_p0;
  logic [6:0]       opc_p0;
  logic [4:0]       fun5_p0;
  logic [NREGS-1:0] busy, busy_eff, busy_nxt;
  logic [3:0]       inflight_q, inflight_eff;
  logic             wb_hit, hazard, accept, issue_wr;
  logic             unused_bits;

  assign opc_p0      = in_instr[6:0];
  assign fun5_p0     = in_instr[31:27];
  assign unused_bits = ^in_instr[26:25];

  always_comb begin
    bundle_p0           = BUNDLE_IDLE;
    bundle_p0.rm        = in_instr[14:12];
    bundle_p0.fti       = !(opc_p0 == OPC_FP && fun5_p0 == 5'b01000);
    bundle_p0.wr_enable = 1'b1;
    use1_p0             = 1'b1;
    use2_p0             = 1'b1;
    use3_p0             = 1'b0;
    case (opc_p0)
      OPC_FP: begin
        case ({fun5_p0, in_instr[14:12]})
          8'b00000_000: bundle_p0.ena = 4'd1;
          8'b00001_000: begin bundle_p0.ena = 4'd1; bundle_p0.op = 1'b1; end
          8'b00010_000: bundle_p0.ena = 4'd2;
          8'b00011_000: bundle_p0.ena = 4'd3;
          8'b01011_000: begin bundle_p0.ena = 4'd4; use2_p0 = 1'b0; end
          8'b00100_000: begin bundle_p0.ena = 4'd5; bundle_p0.sel1 = 2'd1; end
          8'b00100_001: begin bundle_p0.ena = 4'd5; bundle_p0.sel1 = 2'd2; end
          8'b00100_010: begin bundle_p0.ena = 4'd5; bundle_p0.sel1 = 2'd3; end
          8'b00101_000: begin bundle_p0.ena = 4'd6; bundle_p0.sel2 = 3'd1; end
          8'b00101_001: begin bundle_p0.ena = 4'd6; bundle_p0.sel2 = 3'd2; end
          8'b10100_010: begin bundle_p0.ena = 4'd6; bundle_p0.sel2 = 3'd3; end
          8'b10100_001: begin bundle_p0.ena = 4'd6; bundle_p0.sel2 = 3'd4; end
          8'b10100_000: begin bundle_p0.ena = 4'd6; bundle_p0.sel2 = 3'd5; end
          // int-to-float sources come from the integer side, so no FP source is tracked
          8'b01001_000: begin bundle_p0.ena = 4'd7; use1_p0 = 1'b0; use2_p0 = 1'b0; end
          8'b01000_000: begin bundle_p0.ena = 4'd8; use2_p0 = 1'b0; end
          default:      bundle_p0.illegal = 1'b1;
        endcase
      end
      OPC_FMA, OPC_FMS: begin
        bundle_p0.ena = 4'd9;
        bundle_p0.op  = (opc_p0 == OPC_FMS);
        use3_p0       = 1'b1;
      end
      OPC_ST: begin
        bundle_p0.sp        = 1'b0;
        bundle_p0.wr_enable = 1'b0;
      end
      default: bundle_p0.illegal = 1'b1;
    endcase
    if (bundle_p0.illegal) begin
      bundle_p0.wr_enable = 1'b0;
      use1_p0             = 1'b0;
      use2_p0             = 1'b0;
      use3_p0             = 1'b0;
    end else begin
      bundle_p0.rs1 = in_instr[19:15];
      bundle_p0.rs2 = use2_p0 ? in_instr[24:20] : 5'd0;
      bundle_p0.rs3 = use3_p0 ? fun5_p0 : 5'd0;
      bundle_p0.rd  = bundle_p0.wr_enable ? in_instr[11:7] : 5'd0;
    end
  end

  // A completing writeback this cycle frees its register and its in-flight slot immediately
  always_comb begin
    busy_eff = busy;
    if (wb_valid) busy_eff[wb_rd[IDX_W-1:0]] = 1'b0;
  end

  assign wb_hit       = wb_valid && busy[wb_rd[IDX_W-1:0]];
  assign inflight_eff = inflight_q - {3'b000, wb_hit};
  assign hazard = (use1_p0 && busy_eff[bundle_p0.rs1[IDX_W-1:0]]) ||
                  (use2_p0 && busy_eff[bundle_p0.rs2[IDX_W-1:0]]) ||
                  (use3_p0 && busy_eff[bundle_p0.rs3[IDX_W-1:0]]) ||
                  (bundle_p0.wr_enable && (busy_eff[bundle_p0.rd[IDX_W-1:0]] ||
                                           inflight_eff == 4'(MAX_INFLIGHT)));
  assign in_ready = !rst && !flush && (!vld_p1 || out_ready) &&
                    (bundle_p0.illegal ? (ILLEGAL_STALL == 0) : !hazard);
  assign accept   = in_valid && in_ready;
  assign issue_wr = accept && bundle_p0.wr_enable;

  always_comb begin
    busy_nxt = busy;
    if (wb_hit)   busy_nxt[wb_rd[IDX_W-1:0]] = 1'b0;
    if (issue_wr) busy_nxt[bundle_p0.rd[IDX_W-1:0]] = 1'b1;
  end

  // Stage p0 -> p1: decoded bundle register under the downstream handshake
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= BUNDLE_IDLE;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= bundle_p0;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= BUNDLE_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy       <= '0;
      inflight_q <= 4'd0;
    end else begin
      busy       <= busy_nxt;
      inflight_q <= inflight_q + {3'b000, issue_wr} - {3'b000, wb_hit};
    end
  end

  assign out_valid      = vld_p1;
  assign ena            = bundle_p1.ena;
  assign rm             = bundle_p1.rm;
  assign sel1           = bundle_p1.sel1;
  assign sel2           = bundle_p1.sel2;
  assign op             = bundle_p1.op;
  assign rs1            = bundle_p1.rs1;
  assign rs2            = bundle_p1.rs2;
  assign rs3            = bundle_p1.rs3;
  assign rd             = bundle_p1.rd;
  assign wr_enable      = bundle_p1.wr_enable;
  assign sp             = bundle_p1.sp;
  assign logic_fti_ctrl = bundle_p1.fti;
  assign illegal        = bundle_p1.illegal;
  assign inflight       = inflight_q;

`ifdef PSIMD_DEC_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (accept && issue_cnt != 32'hFFFF_FFFF) issue_cnt <= issue_cnt + 32'd1;
      if (in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_issue = issue_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_issue = 32'd0;
  assign perf_stall = 32'd0;
`endif
endmodule

// File: doc/psimd_decode_stage.md
Name: psimd_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the PSIMD DLFloat unit.
- Decodes the custom FP opcodes:
  - OP-FP 1011011
  - FMA 0011011
  - FMS 0111011
  - store 0101011
- Tracks in-flight FP destinations in a scoreboard and stalls the instruction on RAW/WAW hazards.
- Sits between instruction fetch (valid/ready) and the lane datapath (valid/ready); writeback returns completions.

Parameters:
- NREGS, 32, number of FP registers tracked (power of two, at most 32).
- MAX_INFLIGHT, 4, maximum outstanding register-writing instructions (1..15).
- ILLEGAL_STALL, 0, 1 = hold illegal instructions in the input stage (in_ready low); 0 = pass them downstream flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted this cycle.
- in_instr  in  32  instruction word.
- flush  in  1  drop output register, clear scoreboard and counter.
- wb_valid  in  1  writeback completion.
- wb_rd  in  5  register completed.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- ena  out  4  unit select.
- rm  out  3  instr[14:12].
- sel1  out  2  sign-inject mode.
- sel2  out  3  compare/minmax mode.
- op  out  1  add/sub, fma/fms select.
- rs1, rs2, rs3, rd  out  5 each  register indices.
- wr_enable  out  1  bundle writes rd.
- sp  out  1  0 = store, 1 = otherwise.
- logic_fti_ctrl  out  1  0 when fun5 = 01000.
- illegal  out  1  unrecognised encoding.
- inflight  out  4  outstanding write count.
- perf_issue, perf_stall  out  32 each  counters (see Optional Feature).

Behaviour:
- Reset: all outputs 0 except sp = 1 and logic_fti_ctrl = 1; scoreboard and inflight are 0; in_ready reads 0 during rst.
- Decode uses fun5 = instr[31:27] and rm = instr[14:12]. For OP-FP, {fun5,rm} selects the following (anything else = illegal):
  - 00000_000: add, ena 0001, op 0.
  - 00001_000: sub, ena 0001, op 1.
  - 00010_000: mul, ena 0010.
  - 00011_000: div, ena 0011.
  - 01011_000: sqrt, ena 0100.
  - 00100_000/001/010: sign inject, ena 0101, sel1 01/10/11.
  - 00101_000/001: min/max, ena 0110, sel2 001/010.
  - 10100_010/001/000: eq/lt/le, ena 0110, sel2 011/100/101.
  - 01001_000: int-to-float, ena 0111.
  - 01000_000: float-to-int, ena 1000.
  - FMA: ena 1001, op 0. FMS: ena 1001, op 1.
  - Store: ena 0000, sp 0, wr_enable 0.
  - Any other opcode is illegal.
- Register fields:
  - rs1 = instr[19:15] and rd = instr[11:7] for all legal instructions (store: rd = 0).
  - rs2 = instr[24:20], except 0 for sqrt, int-to-float and float-to-int.
  - rs3 = instr[31:27] for FMA/FMS only, else 0.
- Sources used:
  - rs1 always.
  - rs2 unless sqrt, int-to-float or float-to-int.
  - rs3 for FMA/FMS.
  - int-to-float reads no FP source.
- wr_enable = 1 for every legal non-store instruction; illegal bundles force ena = 0 and wr_enable = 0.
- Latency: 1 cycle from acceptance to out_valid.
- Output register:
  - Loads on accept.
  - Held stable while out_valid && !out_ready.
  - Clears when out_ready && !accept.
- Hazard = any used source busy, or (wr_enable && busy[rd]), or (wr_enable && inflight == MAX_INFLIGHT).
  - A same-cycle wb_valid on a register counts as not busy (bypass).
  - A same-cycle wb that decrements inflight relieves the MAX_INFLIGHT limit.
- in_ready = !rst && !flush && (!out_valid || out_ready) && !hazard. Illegal instructions skip the hazard check and are held when ILLEGAL_STALL = 1.
- Scoreboard:
  - Accept with wr_enable sets busy[rd] and increments inflight.
  - wb_valid on a busy register clears it and decrements inflight.
  - wb_valid on a non-busy register is ignored.
  - Simultaneous set and clear of the same register: busy stays 1; inflight unchanged.
- flush takes priority over accept and writeback: out_valid = 0, scoreboard = 0, inflight = 0 next cycle.

Optional Feature:
- Macro PSIMD_DEC_PERF_EN.
- Defined:
  - perf_issue counts accepted instructions.
  - perf_stall counts cycles with in_valid && !in_ready.
  - Both saturate at 0xFFFFFFFF and clear on rst only (flush does not clear them).
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- rst, then add f3,f1,f2 (0x002081DB) with out_ready = 1 -> next cycle out_valid 1, ena 0001, op 0, rs1 1, rs2 2, rd 3, wr_enable 1, inflight 1.
- add 0x002081DB, then mul f4,f3,f5 (0x1051825B) -> mul stalled (in_ready 0, perf_stall increments) until wb_valid with wb_rd 3; accepted in that same cycle; busy[4] = 1.
- Issue 4 writers to f8..f11 with no writeback -> 5th writer stalls at inflight 4; wb_rd 8 -> accepted the same cycle, inflight stays 4.
- instr 0xFFFFFFDB (OP-FP, undefined fun5) -> illegal 1, ena 0, wr_enable 0, inflight unchanged.
- out_ready held 0 for 3 cycles with out_valid 1 -> bundle stable, in_ready 0; simultaneous wb and new issue to the same rd -> busy remains 1.
- flush while inflight = 3 and out_valid = 1 -> next cycle out_valid 0, inflight 0, previously stalled instruction accepted.
